generic_ping_pong_counter: RTL and testbench
============================================

GENERIC_PING_PONG_COUNTER -- requirements
Module: generic_ping_pong_counter

Interface
REQ-001 Parameter WIDTH, default 4, bit width of count, bounds, step and load value.
REQ-002 Parameter RST_DIR, default 1'b1, direction after reset (1 = up, 0 = down).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tick  input  1  count strobe; one step per cycle with tick=1.
REQ-006 enable  input  1  0 freezes count and direction on tick; flip and load still act.
REQ-007 mode  input  2  00 bounce, 01 wrap, 10 one-shot, 11 reserved (hold).
REQ-008 flip  input  1  single-cycle pulse; reverses direction.
REQ-009 load  input  1  single-cycle pulse; loads load_val.
REQ-010 load_val  input  WIDTH  value for load.
REQ-011 max, min  input  WIDTH each  inclusive upper and lower bounds, unsigned.
REQ-012 step  input  WIDTH  increment per tick, unsigned.
REQ-013 cnt  output  WIDTH  registered count.
REQ-014 direction  output  1  registered; 1 up, 0 down.
REQ-015 turn  output  1  registered one-cycle pulse on a bound event (bounce reversal, wrap, one-shot stop).
REQ-016 done  output  1  registered; high while one-shot is halted at its bound.

Function
REQ-017 Priority per cycle SHALL be: rst > load > flip > tick.
REQ-018 load: cnt <= load_val clamped to [min,max]; direction unchanged; done <= 0; turn <= 0.
REQ-019 flip without load: direction <= ~direction; cnt unchanged; done <= 0; turn <= 0.
REQ-020 A tick is active only when enable=1, max>min, step!=0 and mode!=11; otherwise all state holds and turn <= 0.
REQ-021 Next-value arithmetic SHALL use WIDTH+1 bits; no silent wrap of cnt+step or cnt-step.
REQ-022 Out-of-range: on an active tick with cnt<min or cnt>max (bounds changed), cnt <= nearest bound; no step taken; turn <= 0.
REQ-023 Bounce, up: cnt+step >= max -> cnt <= max, direction <= 0, turn <= 1; else cnt <= cnt+step.
REQ-024 Bounce, down: cnt-step <= min (signed compare) -> cnt <= min, direction <= 1, turn <= 1; else cnt <= cnt-step.
REQ-025 Wrap, up: cnt+step > max -> cnt <= min, turn <= 1; down: cnt-step < min -> cnt <= max, turn <= 1; direction never changes.
REQ-026 One-shot: same as bounce except at the bound direction is unchanged, done <= 1, turn <= 1; while done=1, ticks hold; only flip, load or rst clear done.
REQ-027 turn SHALL be 0 in every cycle not named in REQ-023..026.
REQ-028 Latency: every input acts on the next rising edge; outputs have no combinational path from inputs.

Reset
REQ-029 rst=1 at a clock edge SHALL set cnt <= min, direction <= RST_DIR, turn <= 0, done <= 0, overriding all other inputs, including mid-count or while done=1.

Structure
REQ-030 Shared package SHALL hold the mode encodings (MODE_BOUNCE, MODE_WRAP, MODE_ONESHOT, MODE_RSVD) and direction constants DIR_UP/DIR_DOWN.
REQ-031 One sub-module, ppc_step_calc: combinational next cnt/direction/turn/done from current state, mode, bounds and step; the top module holds registers and priority logic.

Verification (WIDTH=4, RST_DIR=1)
REQ-032 min=2, max=9, step=3, bounce, tick every cycle after rst -> cnt 2,5,8,9(turn=1,dir=0),6,3,2(turn=1,dir=1),5.
REQ-033 min=0, max=10, step=4, wrap, up -> cnt 0,4,8,0(turn=1); flip, then ticks -> 10(turn=1),6,2,10; direction stays 0.
REQ-034 min=1, max=15, step=7, one-shot from 1 -> 8,15(done=1,turn=1), further ticks hold 15; flip -> done=0, dir=0, next tick 8; cnt never exceeds 15 (5-bit compare).
REQ-035 Same cycle load=1 (load_val=12), flip=1, tick=1, min=3, max=9 -> cnt=9, direction unchanged, turn=0; next cycle rst=1 with load=1 -> cnt=3, dir=1.
REQ-036 max=min=5, or step=0, or enable=0, or mode=11 with tick=1 for 8 cycles -> cnt, direction, done frozen, turn=0; cnt=12 then bounds changed to [2,7] -> next active tick cnt=7, turn=0.

Source files
------------

// File: rtl/generic_ping_pong_counter_pkg.sv
// Shared encodings for the ping-pong counter: count modes and direction values.
package generic_ping_pong_counter_pkg;

   typedef enum logic [1:0] {
      MODE_BOUNCE  = 2'b00,
      MODE_WRAP    = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_RSVD    = 2'b11
   } ppc_mode_e;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/ppc_step_calc.sv
// Combinational next-state for one count tick: range repair, bounce/wrap/one-shot stepping.
module ppc_step_calc
   import generic_ping_pong_counter_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             active_i,
   input  logic [WIDTH-1:0] cnt_i,
   input  logic             dir_i,
   input  logic             done_i,
   input  logic [1:0]       mode_i,
   input  logic [WIDTH-1:0] min_i,
   input  logic [WIDTH-1:0] max_i,
   input  logic [WIDTH-1:0] step_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             dir_o,
   output logic             turn_o,
   output logic             done_o
);

   ppc_mode_e               mode;
   logic                    go;
   logic [WIDTH:0]          sum;
   logic signed [WIDTH+1:0] diff;
   logic signed [WIDTH+1:0] lo_s;
   logic [WIDTH:0]          hi_u;
   logic                    hit_up;
   logic                    hit_dn;

   always_comb begin
      mode = ppc_mode_e'(mode_i);
      // one extra bit up, two down, so neither cnt+step nor cnt-step can wrap
      sum  = {1'b0, cnt_i} + {1'b0, step_i};
      diff = $signed({2'b00, cnt_i}) - $signed({2'b00, step_i});
      lo_s = $signed({2'b00, min_i});
      hi_u = {1'b0, max_i};

      if (mode == MODE_WRAP) begin
         hit_up = (sum > hi_u);
         hit_dn = (diff < lo_s);
      end else begin
         hit_up = (sum >= hi_u);
         hit_dn = (diff <= lo_s);
      end

      go = active_i && (max_i > min_i) && (step_i != '0) &&
           (mode != MODE_RSVD) && !done_i;

      cnt_o  = cnt_i;
      dir_o  = dir_i;
      turn_o = 1'b0;
      done_o = done_i;

      if (go) begin
         if (cnt_i < min_i) begin
            cnt_o = min_i;
         end else if (cnt_i > max_i) begin
            cnt_o = max_i;
         end else if (dir_i == DIR_UP) begin
            if (hit_up) begin
               turn_o = 1'b1;
               case (mode)
                  MODE_WRAP: cnt_o = min_i;
                  MODE_ONESHOT: begin
                     cnt_o  = max_i;
                     done_o = 1'b1;
                  end
                  default: begin
                     cnt_o = max_i;
                     dir_o = DIR_DOWN;
                  end
               endcase
            end else begin
               cnt_o = sum[WIDTH-1:0];
            end
         end else begin
            if (hit_dn) begin
               turn_o = 1'b1;
               case (mode)
                  MODE_WRAP: cnt_o = max_i;
                  MODE_ONESHOT: begin
                     cnt_o  = min_i;
                     done_o = 1'b1;
                  end
                  default: begin
                     cnt_o = min_i;
                     dir_o = DIR_UP;
                  end
               endcase
            end else begin
               cnt_o = diff[WIDTH-1:0];
            end
         end
      end
   end

endmodule

// File: rtl/generic_ping_pong_counter.sv
// Ping-pong counter: registered state with rst > load > flip > tick priority.
module generic_ping_pong_counter
   import generic_ping_pong_counter_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter logic        RST_DIR = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic             flip,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] max,
   input  logic [WIDTH-1:0] min,
   input  logic [WIDTH-1:0] step,
   output logic [WIDTH-1:0] cnt,
   output logic             direction,
   output logic             turn,
   output logic             done
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             turn_q, turn_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] calc_cnt;
   logic             calc_dir;
   logic             calc_turn;
   logic             calc_done;
   logic [WIDTH-1:0] load_clamped;

   ppc_step_calc #(
      .WIDTH (WIDTH)
   ) u_step_calc (
      .active_i (tick & enable),
      .cnt_i    (cnt_q),
      .dir_i    (dir_q),
      .done_i   (done_q),
      .mode_i   (mode),
      .min_i    (min),
      .max_i    (max),
      .step_i   (step),
      .cnt_o    (calc_cnt),
      .dir_o    (calc_dir),
      .turn_o   (calc_turn),
      .done_o   (calc_done)
   );

   always_comb begin
      if (load_val < min) begin
         load_clamped = min;
      end else if (load_val > max) begin
         load_clamped = max;
      end else begin
         load_clamped = load_val;
      end

      cnt_d  = calc_cnt;
      dir_d  = calc_dir;
      turn_d = calc_turn;
      done_d = calc_done;

      if (load) begin
         cnt_d  = load_clamped;
         dir_d  = dir_q;
         turn_d = 1'b0;
         done_d = 1'b0;
      end else if (flip) begin
         cnt_d  = cnt_q;
         dir_d  = ~dir_q;
         turn_d = 1'b0;
         done_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= min;
         dir_q  <= RST_DIR;
         turn_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dir_q  <= dir_d;
         turn_q <= turn_d;
         done_q <= done_d;
      end
   end

   assign cnt       = cnt_q;
   assign direction = dir_q;
   assign turn      = turn_q;
   assign done      = done_q;

endmodule

// File: tb/tb_generic_ping_pong_counter.sv
// Directed and randomized check of generic_ping_pong_counter against an integer reference model.
module tb_generic_ping_pong_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       enable = 1'b1;
   logic [1:0] mode = 2'b00;
   logic       flip = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = '0;
   logic [3:0] max = '0;
   logic [3:0] min = '0;
   logic [3:0] step = '0;
   logic [3:0] cnt;
   logic       direction;
   logic       turn;
   logic       done;

   int ncmp = 0;
   int nfail = 0;

   int m_cnt = 0;
   int m_dir = 1;
   int m_turn = 0;
   int m_done = 0;

   always #5 clk = ~clk;

   generic_ping_pong_counter #(
      .WIDTH   (4),
      .RST_DIR (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .enable    (enable),
      .mode      (mode),
      .flip      (flip),
      .load      (load),
      .load_val  (load_val),
      .max       (max),
      .min       (min),
      .step      (step),
      .cnt       (cnt),
      .direction (direction),
      .turn      (turn),
      .done      (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: integer arithmetic straight from the counting rules.
   task automatic model_update();
      int lo, hi, st, nxt, lv;
      lo = int'(min); hi = int'(max); st = int'(step); lv = int'(load_val);
      m_turn = 0;
      if (rst) begin
         m_cnt = lo; m_dir = 1; m_done = 0;
      end else if (load) begin
         m_cnt = (lv < lo) ? lo : (lv > hi) ? hi : lv;
         m_done = 0;
      end else if (flip) begin
         m_dir = 1 - m_dir; m_done = 0;
      end else if (tick && enable && hi > lo && st != 0 && mode != 2'b11 && m_done == 0) begin
         if (m_cnt < lo) m_cnt = lo;
         else if (m_cnt > hi) m_cnt = hi;
         else begin
            nxt = (m_dir == 1) ? m_cnt + st : m_cnt - st;
            if (mode == 2'b01) begin
               if (m_dir == 1 && nxt > hi) begin m_cnt = lo; m_turn = 1; end
               else if (m_dir == 0 && nxt < lo) begin m_cnt = hi; m_turn = 1; end
               else m_cnt = nxt;
            end else if ((m_dir == 1 && nxt >= hi) || (m_dir == 0 && nxt <= lo)) begin
               m_cnt = (m_dir == 1) ? hi : lo;
               m_turn = 1;
               if (mode == 2'b10) m_done = 1;
               else m_dir = 1 - m_dir;
            end else m_cnt = nxt;
         end
      end
   endtask

   task automatic cycle();
      model_update();
      @(posedge clk);
      #1;
      chk("cnt", {28'b0, cnt}, m_cnt);
      chk("direction", {31'b0, direction}, m_dir);
      chk("turn", {31'b0, turn}, m_turn);
      chk("done", {31'b0, done}, m_done);
   endtask

   task automatic set_cfg(input int lo, input int hi, input int st, input int md);
      min = 4'(lo); max = 4'(hi); step = 4'(st); mode = 2'(md);
   endtask

   task automatic clear_ctl();
      rst = 1'b0; load = 1'b0; flip = 1'b0; tick = 1'b1; enable = 1'b1;
   endtask

   int exp_b[7] = '{5, 8, 9, 6, 3, 2, 5};
   int exp_bt[7] = '{0, 0, 1, 0, 0, 1, 0};
   int exp_w[7] = '{4, 8, 0, 0, 10, 6, 2};

   initial begin
      // Bounce 2..9 step 3
      set_cfg(2, 9, 3, 0); clear_ctl(); rst = 1'b1;
      cycle();
      chk("rst_cnt", {28'b0, cnt}, 2);
      chk("rst_dir", {31'b0, direction}, 1);
      rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         cycle();
         chk("bounce_cnt", {28'b0, cnt}, exp_b[i]);
         chk("bounce_turn", {31'b0, turn}, exp_bt[i]);
      end

      // Wrap 0..10 step 4, flip in the middle
      set_cfg(0, 10, 4, 1); rst = 1'b1; cycle(); rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         flip = (i == 3);
         cycle();
         chk("wrap_cnt", {28'b0, cnt}, exp_w[i]);
      end
      flip = 1'b0;
      cycle();
      chk("wrap_cnt_last", {28'b0, cnt}, 10);
      chk("wrap_turn_last", {31'b0, turn}, 1);
      chk("wrap_dir", {31'b0, direction}, 0);

      // One-shot 1..15 step 7
      set_cfg(1, 15, 7, 2); rst = 1'b1; cycle(); rst = 1'b0;
      cycle(); chk("os_cnt8", {28'b0, cnt}, 8);
      cycle(); chk("os_cnt15", {28'b0, cnt}, 15);
      chk("os_done", {31'b0, done}, 1);
      chk("os_turn", {31'b0, turn}, 1);
      for (int i = 0; i < 3; i++) begin
         cycle(); chk("os_hold", {28'b0, cnt}, 15);
      end
      flip = 1'b1; cycle(); flip = 1'b0;
      chk("os_flip_done", {31'b0, done}, 0);
      chk("os_flip_dir", {31'b0, direction}, 0);
      cycle(); chk("os_down", {28'b0, cnt}, 8);

      // Priority: load over flip over tick, rst over load
      set_cfg(3, 9, 2, 0);
      load_val = 4'd12; load = 1'b1; flip = 1'b1;
      cycle();
      chk("load_clamp", {28'b0, cnt}, 9);
      chk("load_turn", {31'b0, turn}, 0);
      chk("load_dir", {31'b0, direction}, 0);
      flip = 1'b0; rst = 1'b1;
      cycle();
      chk("rst_over_load", {28'b0, cnt}, 3);
      chk("rst_over_load_dir", {31'b0, direction}, 1);
      clear_ctl();

      // Frozen cases: degenerate bounds, zero step, disabled, reserved mode
      set_cfg(5, 5, 3, 0); rst = 1'b1; cycle(); rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: set_cfg(5, 5, 3, 0);
            1: set_cfg(2, 9, 0, 0);
            2: begin set_cfg(2, 9, 3, 0); enable = 1'b0; end
            default: begin set_cfg(2, 9, 3, 3); enable = 1'b1; end
         endcase
         for (int i = 0; i < 8; i++) begin
            cycle(); chk("frozen", {28'b0, cnt}, 5);
         end
      end

      // Out-of-range repair after bounds shrink
      set_cfg(0, 15, 3, 0); load_val = 4'd12; load = 1'b1; cycle(); load = 1'b0;
      set_cfg(2, 7, 3, 0); cycle();
      chk("oor_cnt", {28'b0, cnt}, 7);
      chk("oor_turn", {31'b0, turn}, 0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         rst      = ($urandom_range(0, 49) == 0);
         load     = ($urandom_range(0, 11) == 0);
         flip     = ($urandom_range(0, 11) == 0);
         tick     = ($urandom_range(0, 3) != 0);
         enable   = ($urandom_range(0, 9) != 0);
         load_val = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) begin
            min  = 4'($urandom_range(0, 15));
            max  = 4'($urandom_range(0, 15));
            step = 4'($urandom_range(0, 15));
            mode = 2'($urandom_range(0, 3));
         end
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
